// File: rtl/vp_shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier: one WIDTH x WIDTH product or two packed
// (WIDTH/2 x WIDTH/2) lane products. Optional early termination: VPM_EARLY_TERM_EN.
module vp_shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_mode,
    output logic               busy
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mc_lo, mc_hi;
    logic [HALF-1:0]  mp_lo, mp_hi;
    logic             mode_r;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             bit_lo, bit_hi;
    logic [WIDTH-1:0] add_lo, add_hi;
    logic [WIDTH:0]   sum_lo;
    logic             carry_mid;
    logic [WIDTH-1:0] sum_hi;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mc_lo_nxt, mc_hi_nxt;
    logic [HALF-1:0]  mp_lo_nxt, mp_hi_nxt;
    logic             iter_last;
    logic             run_end;

    logic in_ready_d, out_valid_d, busy_d;

    assign accept = (state == S_IDLE) && in_valid && in_ready;

    // Split accumulation adder; the mid carry is blocked in dual-lane mode
    always_comb begin
        bit_lo    = mp_lo[0];
        bit_hi    = mode_r ? mp_hi[0] : mp_lo[0];
        add_lo    = bit_lo ? mc_lo : '0;
        add_hi    = bit_hi ? mc_hi : '0;
        sum_lo    = {1'b0, acc[WIDTH-1:0]} + {1'b0, add_lo};
        carry_mid = sum_lo[WIDTH] & ~mode_r;
        sum_hi    = acc[PW-1:WIDTH] + add_hi + WIDTH'(carry_mid);
        acc_nxt   = {sum_hi, sum_lo[WIDTH-1:0]};
    end

    // Operand shifters: one 2W/W pair in full mode, independent halves in lane mode
    always_comb begin
        if (mode_r) begin
            mc_lo_nxt = mc_lo << 1;
            mc_hi_nxt = mc_hi << 1;
            mp_lo_nxt = mp_lo >> 1;
            mp_hi_nxt = mp_hi >> 1;
        end else begin
            {mc_hi_nxt, mc_lo_nxt} = {mc_hi, mc_lo} << 1;
            {mp_hi_nxt, mp_lo_nxt} = {mp_hi, mp_lo} >> 1;
        end
    end

    assign iter_last = (cnt == (mode_r ? CW'(HALF - 1) : CW'(WIDTH - 1)));

`ifdef VPM_EARLY_TERM_EN
    assign run_end = iter_last || ({mp_hi_nxt, mp_lo_nxt} == '0);
`else
    assign run_end = iter_last;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (run_end) state_nxt = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_nxt)
            S_IDLE:  in_ready_d  = 1'b1;
            S_RUN:   busy_d      = 1'b1;
            S_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Datapath: operand capture, iteration, result hand-off on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_lo    <= '0;
            mc_hi    <= '0;
            mp_lo    <= '0;
            mp_hi    <= '0;
            mode_r   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            product  <= '0;
            out_mode <= 1'b0;
        end else begin
            if (accept) begin
                mc_lo  <= mode ? WIDTH'(a[HALF-1:0]) : a;
                mc_hi  <= mode ? WIDTH'(a[WIDTH-1:HALF]) : '0;
                mp_lo  <= b[HALF-1:0];
                mp_hi  <= b[WIDTH-1:HALF];
                mode_r <= mode;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_RUN) begin
                acc   <= acc_nxt;
                mc_lo <= mc_lo_nxt;
                mc_hi <= mc_hi_nxt;
                mp_lo <= mp_lo_nxt;
                mp_hi <= mp_hi_nxt;
                cnt   <= cnt + CW'(1);
                if (run_end) begin
                    product  <= acc_nxt;
                    out_mode <= mode_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_vp_shift_add_multiplier.sv
// Self-checking bench for vp_shift_add_multiplier against an arithmetic reference model.
module tb_vp_shift_add_multiplier;

    localparam int unsigned W = 8;
    localparam int unsigned H = W / 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           out_mode;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    vp_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .out_mode(out_mode), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] av, input logic [W-1:0] bv,
                                                   input logic m);
        logic [W-1:0] lo, hi;
        if (!m) return (2*W)'(av) * (2*W)'(bv);
        lo = W'(av[H-1:0]) * W'(bv[H-1:0]);
        hi = W'(av[W-1:H]) * W'(bv[W-1:H]);
        return {hi, lo};
    endfunction

    function automatic int top_bit_count(input logic [W-1:0] v, input int nbits);
        int n = 0;
        for (int i = 0; i < nbits; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] bv, input logic m);
`ifdef VPM_EARLY_TERM_EN
        int n;
        logic [W-1:0] hi_bits;
        hi_bits = bv >> H;
        if (!m) n = top_bit_count(bv, W);
        else    n = (top_bit_count(bv, H) > top_bit_count(hi_bits, H)) ?
                    top_bit_count(bv, H) : top_bit_count(hi_bits, H);
        return (n < 1) ? 1 : n;
`else
        return m ? int'(H) : int'(W);
`endif
    endfunction

    // Presents one operation, returns cycles from acceptance edge to out_valid
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                         input logic rdy, output logic rdy_seen, output int lat);
        a = av; b = bv; mode = m; in_valid = 1'b1; out_ready = rdy;
        rdy_seen = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || product !== '0 || busy !== 1'b0 || out_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b product=%h busy=%b out_mode=%b, required all 0",
                     in_ready, out_valid, product, busy, out_mode);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 0000 0",
                     in_ready, out_valid, product, busy);
        end
    endtask

    // Directed products from the table, plus model-derived latency
    task automatic test_directed();
        logic [W-1:0]   ta [7] = '{8'hFF, 8'h00, 8'h0D, 8'hF3, 8'hFF, 8'h55, 8'h12};
        logic [W-1:0]   tb [7] = '{8'hFF, 8'hA5, 8'h0B, 8'hE5, 8'hFF, 8'h03, 8'h34};
        logic           tm [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2*W-1:0] tp [7] = '{16'hFE01, 16'h0000, 16'h008F, 16'hD20F, 16'hE1E1, 16'h00FF, 16'h03A8};
        logic rs;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], tm[i], 1'b1, rs, lat);
            checks++;
            if (rs !== 1'b1 || lat !== ref_latency(tb[i], tm[i])) begin
                failures++;
                $display("FAIL directed_latency[%0d]: in_ready=%b latency=%0d, required 1 %0d",
                         i, rs, lat, ref_latency(tb[i], tm[i]));
            end
            checks++;
            if (product !== tp[i] || out_mode !== tm[i]) begin
                failures++;
                $display("FAIL directed_product[%0d]: product=%h out_mode=%b, required %h %b",
                         i, product, out_mode, tp[i], tm[i]);
            end
            drain();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL directed_return[%0d]: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                         i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv;
        logic m, rs;
        int lat;
        logic [2*W-1:0] exp_p;
        for (int i = 0; i < 40; i++) begin
            av = W'($urandom); bv = W'($urandom); m = 1'($urandom);
            if (i % 8 == 0) bv = W'($urandom_range(0, 3));
            exp_p = ref_product(av, bv, m);
            do_op(av, bv, m, 1'b1, rs, lat);
            checks++;
            if (rs !== 1'b1 || lat !== ref_latency(bv, m) || product !== exp_p || out_mode !== m) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h m=%b: product=%h out_mode=%b latency=%0d, required %h %b %0d",
                         i, av, bv, m, product, out_mode, lat, exp_p, m, ref_latency(bv, m));
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic rs;
        int lat;
        logic [2*W-1:0] exp_p;
        exp_p = ref_product(8'hB7, 8'h6D, 1'b0);
        do_op(8'hB7, 8'h6D, 1'b0, 1'b0, rs, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || product !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure[%0d]: out_valid=%b product=%h in_ready=%b busy=%b, required 1 %h 0 1",
                         i, out_valid, product, in_ready, busy, exp_p);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp_p) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b product=%h, required 0 1 %h",
                     out_valid, in_ready, product, exp_p);
        end
        // Idle with in_valid low must stay idle and keep the last product
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== exp_p) begin
            failures++;
            $display("FAIL idle_hold: in_ready=%b busy=%b out_valid=%b product=%h, required 1 0 0 %h",
                     in_ready, busy, out_valid, product, exp_p);
        end
    endtask

    task automatic test_reset_mid();
        logic rs;
        int lat;
        a = 8'h12; b = 8'h34; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || product !== '0 || busy !== 1'b0 || out_mode !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b product=%h busy=%b out_mode=%b, required all 0",
                     in_ready, out_valid, product, busy, out_mode);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h12, 8'h34, 1'b0, 1'b1, rs, lat);
        checks++;
        if (rs !== 1'b1 || product !== 16'h03A8 || lat !== ref_latency(8'h34, 1'b0)) begin
            failures++;
            $display("FAIL reset_mid_rerun: in_ready=%b product=%h latency=%0d, required 1 03a8 %0d",
                     rs, product, lat, ref_latency(8'h34, 1'b0));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
